hamming_secded_stream: RTL and testbench
========================================

# hamming_secded_stream

Parametrised, pipelined Hamming decoder that succeeds the combinational single-error-correcting Hamming IP. It adds an optional SECDED mode (extra overall-parity bit), shortened-code support, valid/ready streaming with backpressure, per-word error status and saturating error counters. It sits between a code-word source (channel/memory model) and the data consumer; throughput is one word per cycle, latency is 2 cycles.

## Interface
- IP_BIT, 11, data bits per word (≥1)
- PAR_BIT, 4, Hamming parity bits; must satisfy IP_BIT ≤ 2^PAR_BIT − PAR_BIT − 1
- EXT, 0, 1 = SECDED (extra overall-parity bit), 0 = SEC only
- CNT_W, 16, error-counter width
- Derived: HAM_W = IP_BIT+PAR_BIT; CODE_W = HAM_W+EXT

Clock is `clk`; reset is `rst`, synchronous, active-high.

- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  code word present
- in_ready  out  1  block accepts word this cycle
- in_code  in  CODE_W  received code word
- out_valid  out  1  decoded word present
- out_ready  in  1  consumer accepts word
- out_data  out  IP_BIT  corrected data
- out_err  out  2  00 clean, 01 corrected, 10 uncorrectable (11 never driven)
- clr_cnt  in  1  synchronous counter clear
- corr_cnt  out  CNT_W  corrected-word count
- uncorr_cnt  out  CNT_W  uncorrectable-word count

## Operation
- Bit mapping: Hamming position p (1..HAM_W) = in_code[CODE_W−p]; position 1 is the MSB. When EXT=1, in_code[0] is the overall parity bit (even parity over all CODE_W bits).
- Parity bits occupy positions 2^k. Data bits occupy the remaining positions in ascending order, mapped MSB-first to out_data.
- Syndrome s = XOR of all position indices p whose bit is 1 (PAR_BIT wide). P = XOR of all CODE_W bits (EXT=1 only).
- SEC (EXT=0):
  - s=0 → clean.
  - 1≤s≤HAM_W → flip position s; corrected.
  - s>HAM_W (shortened code) → uncorrectable; out_data is the uncorrected extraction.
- SECDED (EXT=1):
  - s=0, P=0 → clean.
  - s=0, P=1 → error in overall-parity bit; data unchanged; corrected.
  - s≠0, P=1, s≤HAM_W → flip position s; corrected.
  - s≠0, P=1, s>HAM_W → uncorrectable.
  - s≠0, P=0 → double error; uncorrectable.
- Counters:
  - Increment by 1 only on an output handshake (out_valid & out_ready), using out_err of that word.
  - Saturate at 2^CNT_W−1.
  - clr_cnt zeroes both counters next cycle and wins over a simultaneous increment.

## Timing
- Pipeline: S1 registers in_code and computes s/P. S2 registers the corrected data and out_err.
- Handshake / advance rules:
  - adv2 = ~s2_valid | out_ready
  - adv1 = ~s1_valid | adv2
  - in_ready = adv1 (combinational)
  - Word accepted when in_valid & in_ready.
- Latency: a word accepted in cycle n appears at out_valid in cycle n+2 when there is no stall. Sustained throughput is 1 word/cycle.
- Stall: while out_valid & ~out_ready, out_data and out_err hold stable. Up to 2 words stay buffered, and in_ready drops once both stages are full.
- Order is preserved. No word is dropped or duplicated.
- Reset: s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_err=00, corr_cnt=0, uncorr_cnt=0. in_ready=1 in the cycle after reset.
- Reset asserted mid-stream discards in-flight words. Counters are zeroed regardless of clr_cnt.

## Structure
- Package hamming_pkg holds:
  - err_t enum: ERR_NONE=2'b00, ERR_CORR=2'b01, ERR_UNCORR=2'b10
  - function is_pow2(p)
  - function/localparam computing HAM_W and CODE_W
  - elaboration-time check of the IP_BIT/PAR_BIT constraint
- Sub-module hamming_syndrome: combinational, parametrised by IP_BIT/PAR_BIT/EXT; outputs s and P. It is instantiated in S1.
- Correction, data extraction, handshake and counters live in the top.

## Test plan
- IP_BIT=11, PAR_BIT=4, EXT=0; in_code=15'h0000 then 15'h7FFF, out_ready=1 → out_data 11'h000 then 11'h7FF, out_err=00, both visible 2 cycles after acceptance.
- Same config; in_code=15'h0400 (position 5 flipped) → out_data=11'h000, out_err=01, corr_cnt=1.
- IP_BIT=11, PAR_BIT=4, EXT=1:
  - 16'h0001 → out_data=0, out_err=01.
  - 16'h0003 (position 15 plus overall-parity bit) → out_err=10, uncorr_cnt=1.
- IP_BIT=8, PAR_BIT=4, EXT=0; in_code=12'h801 (positions 1 and 12, s=13>12) → out_err=10.
- Backpressure: stream 4 words with out_ready=0 for 3 cycles →
  - in_ready low after 2 words accepted;
  - out_data stable during the stall;
  - after release, all 4 words emerge in order.
- Counters:
  - CNT_W=2, five corrected words → corr_cnt=3 (saturated).
  - clr_cnt asserted on the same cycle as a handshake → both counters 0 next cycle.
  - rst mid-stream → out_valid=0 next cycle.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared definitions for the streaming Hamming SEC/SECDED decoder.
//   err_t       : per-word decode status carried on out_err
//   is_pow2     : true for Hamming positions that hold parity bits
//   calc_ham_w  : Hamming word width (data + parity bits)
//   calc_code_w : received code-word width (Hamming word + optional overall parity)
//   params_ok   : legality of an IP_BIT/PAR_BIT pair, checked at elaboration
package hamming_pkg;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'b00,
    ERR_CORR   = 2'b01,
    ERR_UNCORR = 2'b10
  } err_t;

  function automatic bit is_pow2(input int p);
    return (p > 0) && ((p & (p - 1)) == 0);
  endfunction

  function automatic int calc_ham_w(input int ip_bit, input int par_bit);
    return ip_bit + par_bit;
  endfunction

  function automatic int calc_code_w(input int ip_bit, input int par_bit, input int ext);
    return ip_bit + par_bit + ext;
  endfunction

  // The data bits must fit in the non-power-of-two positions 1..2^PAR_BIT-1.
  function automatic bit params_ok(input int ip_bit, input int par_bit);
    return (ip_bit >= 1) && (par_bit >= 2) && (par_bit < 31) &&
           (ip_bit <= (1 << par_bit) - par_bit - 1);
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome / overall-parity generator.
//   code_i : received code word; Hamming position p sits at code_i[CODE_W-p],
//            and with EXT=1 code_i[0] is the overall parity bit
//   syn_o  : XOR of the position indices of all set bits in positions 1..HAM_W
//   par_o  : XOR of every code bit (EXT=1), tied low when EXT=0
module hamming_syndrome
  import hamming_pkg::*;
#(
  parameter int IP_BIT  = 11,
  parameter int PAR_BIT = 4,
  parameter int EXT     = 0
) (
  input  logic [IP_BIT+PAR_BIT+EXT-1:0] code_i,
  output logic [PAR_BIT-1:0]            syn_o,
  output logic                          par_o
);

  localparam int HAM_W  = calc_ham_w(IP_BIT, PAR_BIT);
  localparam int CODE_W = calc_code_w(IP_BIT, PAR_BIT, EXT);

  always_comb begin
    syn_o = '0;
    for (int p = 1; p <= HAM_W; p++) begin
      if (code_i[CODE_W - p]) syn_o = syn_o ^ PAR_BIT'(p);
    end
  end

  if (EXT != 0) begin : g_ext
    assign par_o = ^code_i;
  end else begin : g_sec
    assign par_o = 1'b0;
  end

endmodule

// File: rtl/hamming_secded_stream.sv
// Two-stage pipelined Hamming decoder with streaming handshake and error counters.
//   clk, rst              : clock and synchronous active-high reset
//   in_valid/in_ready     : input handshake, in_code is the received code word
//   out_valid/out_ready   : output handshake carrying out_data (corrected data)
//                           and out_err (00 clean, 01 corrected, 10 uncorrectable)
//   clr_cnt               : synchronous clear of both counters
//   corr_cnt, uncorr_cnt  : saturating counts of corrected / uncorrectable words
//
// Handshake: a word moves across an interface on a rising edge where valid and
// ready are both high. Once valid is raised the offered word and status stay
// unchanged until that edge. Stage S1 holds the raw code word (syndrome is
// computed from it), stage S2 holds the decoded result that drives the outputs.
// A stage may load whenever it is empty or its own contents leave this cycle,
// so in_ready is combinational and one word per cycle flows without stalls.
module hamming_secded_stream
  import hamming_pkg::*;
#(
  parameter int IP_BIT  = 11,
  parameter int PAR_BIT = 4,
  parameter int EXT     = 0,
  parameter int CNT_W   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IP_BIT+PAR_BIT+EXT-1:0] in_code,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [IP_BIT-1:0]             out_data,
  output logic [1:0]                    out_err,
  input  logic                          clr_cnt,
  output logic [CNT_W-1:0]              corr_cnt,
  output logic [CNT_W-1:0]              uncorr_cnt
);

  localparam int HAM_W  = calc_ham_w(IP_BIT, PAR_BIT);
  localparam int CODE_W = calc_code_w(IP_BIT, PAR_BIT, EXT);

  if (!params_ok(IP_BIT, PAR_BIT)) begin : g_param_check
    $error("hamming_secded_stream: IP_BIT=%0d does not fit PAR_BIT=%0d", IP_BIT, PAR_BIT);
  end

  logic              s1_valid_q;
  logic [CODE_W-1:0] s1_code_q;
  logic              s2_valid_q;
  logic [IP_BIT-1:0] s2_data_q;
  err_t              s2_err_q;

  logic adv1;
  logic adv2;

  assign adv2     = ~s2_valid_q | out_ready;
  assign adv1     = ~s1_valid_q | adv2;
  assign in_ready = adv1;

  logic [PAR_BIT-1:0] s1_syn;
  logic               s1_par;

  hamming_syndrome #(
    .IP_BIT (IP_BIT),
    .PAR_BIT(PAR_BIT),
    .EXT    (EXT)
  ) u_syndrome (
    .code_i(s1_code_q),
    .syn_o (s1_syn),
    .par_o (s1_par)
  );

  logic [HAM_W-1:0]  ham_fixed;
  logic [IP_BIT-1:0] dec_data;
  err_t              dec_err;
  logic              do_flip;

  always_comb begin
    int syn_v;
    int k;
    syn_v   = int'(s1_syn);
    do_flip = 1'b0;
    dec_err = ERR_NONE;
    if (EXT == 0) begin
      if (syn_v == 0) begin
        dec_err = ERR_NONE;
      end else if (syn_v <= HAM_W) begin
        do_flip = 1'b1;
        dec_err = ERR_CORR;
      end else begin
        // Syndrome points past the end of a shortened code.
        dec_err = ERR_UNCORR;
      end
    end else begin
      if (syn_v == 0) begin
        // Only the overall parity bit can be wrong; data is intact.
        dec_err = s1_par ? ERR_CORR : ERR_NONE;
      end else if (!s1_par) begin
        dec_err = ERR_UNCORR;
      end else if (syn_v <= HAM_W) begin
        do_flip = 1'b1;
        dec_err = ERR_CORR;
      end else begin
        dec_err = ERR_UNCORR;
      end
    end

    // Uncorrectable words pass through unflipped.
    ham_fixed = s1_code_q[CODE_W-1 -: HAM_W];
    for (int p = 1; p <= HAM_W; p++) begin
      if (do_flip && (syn_v == p)) ham_fixed[HAM_W - p] = ~ham_fixed[HAM_W - p];
    end

    // Data positions in ascending order fill out_data from the MSB down.
    dec_data = '0;
    k        = IP_BIT - 1;
    for (int p = 1; p <= HAM_W; p++) begin
      if (!is_pow2(p)) begin
        dec_data[k] = ham_fixed[HAM_W - p];
        k--;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_code_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_err_q   <= ERR_NONE;
    end else begin
      if (adv1) begin
        s1_valid_q <= in_valid;
        if (in_valid) s1_code_q <= in_code;
      end
      if (adv2) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= dec_data;
          s2_err_q  <= dec_err;
        end
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_err   = s2_err_q;

  logic             out_hs;
  logic [CNT_W-1:0] corr_cnt_q;
  logic [CNT_W-1:0] corr_cnt_d;
  logic [CNT_W-1:0] uncorr_cnt_q;
  logic [CNT_W-1:0] uncorr_cnt_d;

  assign out_hs = s2_valid_q & out_ready;

  always_comb begin
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (clr_cnt) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else if (out_hs) begin
      if ((s2_err_q == ERR_CORR) && !(&corr_cnt_q)) corr_cnt_d = corr_cnt_q + CNT_W'(1);
      if ((s2_err_q == ERR_UNCORR) && !(&uncorr_cnt_q)) uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;

endmodule

// File: tb/tb_hamming_secded_stream.sv
// Bench for hamming_secded_stream with three configurations:
//   A: IP_BIT=11 PAR_BIT=4 EXT=0 CNT_W=16 (directed vectors, latency)
//   B: IP_BIT=11 PAR_BIT=4 EXT=1 CNT_W=16 (directed, backpressure, random stream)
//   C: IP_BIT=8  PAR_BIT=4 EXT=0 CNT_W=2  (shortened code, saturation, clear, reset)
module tb_hamming_secded_stream;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- DUT A ----------------
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_clr;
  logic [14:0] a_in_code;
  logic [10:0] a_out_data;
  logic [1:0]  a_out_err;
  logic [15:0] a_corr, a_uncorr;

  hamming_secded_stream #(.IP_BIT(11), .PAR_BIT(4), .EXT(0), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_code(a_in_code),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_err(a_out_err),
    .clr_cnt(a_clr), .corr_cnt(a_corr), .uncorr_cnt(a_uncorr)
  );

  // ---------------- DUT B ----------------
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_clr;
  logic [15:0] b_in_code;
  logic [10:0] b_out_data;
  logic [1:0]  b_out_err;
  logic [15:0] b_corr, b_uncorr;

  hamming_secded_stream #(.IP_BIT(11), .PAR_BIT(4), .EXT(1), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_code(b_in_code),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_err(b_out_err),
    .clr_cnt(b_clr), .corr_cnt(b_corr), .uncorr_cnt(b_uncorr)
  );

  // ---------------- DUT C ----------------
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_clr;
  logic [11:0] c_in_code;
  logic [7:0]  c_out_data;
  logic [1:0]  c_out_err;
  logic [1:0]  c_corr, c_uncorr;

  hamming_secded_stream #(.IP_BIT(8), .PAR_BIT(4), .EXT(0), .CNT_W(2)) u_dut_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_code(c_in_code),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data), .out_err(c_out_err),
    .clr_cnt(c_clr), .corr_cnt(c_corr), .uncorr_cnt(c_uncorr)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Encode: data into non-power-of-two positions, then set parity positions 2^j
  // so that the XOR of all set-bit positions becomes zero.
  function automatic logic [31:0] ref_encode(input logic [31:0] data, input int ip,
                                             input int par, input int ext);
    logic [31:0] code;
    int ham, cw, k, s;
    ham  = ip + par;
    cw   = ham + ext;
    code = '0;
    k    = ip - 1;
    s    = 0;
    for (int p = 1; p <= ham; p++) begin
      if ((p & (p - 1)) != 0) begin
        code[cw - p] = data[k];
        k--;
      end
    end
    for (int p = 1; p <= ham; p++) if (code[cw - p]) s = s ^ p;
    for (int j = 0; j < par; j++) if (s[j]) code[cw - (1 << j)] = 1'b1;
    if (ext != 0) code[0] = ^code;
    return code;
  endfunction

  function automatic logic [31:0] ref_extract(input logic [31:0] code, input int ip,
                                              input int par, input int ext);
    logic [31:0] data;
    int ham, cw, k;
    ham  = ip + par;
    cw   = ham + ext;
    data = '0;
    k    = ip - 1;
    for (int p = 1; p <= ham; p++) begin
      if ((p & (p - 1)) != 0) begin
        data[k] = code[cw - p];
        k--;
      end
    end
    return data;
  endfunction

  // Random word with nerr injected bit flips; the expected status follows from
  // the number of flips, not from any syndrome arithmetic.
  task automatic make_word(input int ip, input int par, input int ext, input int nerr,
                           output logic [31:0] code, output logic [31:0] exp_data,
                           output logic [1:0] exp_err);
    logic [31:0] data;
    int cw, i1, i2;
    cw   = ip + par + ext;
    data = $urandom_range(0, (1 << ip) - 1);
    code = ref_encode(data, ip, par, ext);
    i1   = 0;
    if (nerr >= 1) begin
      i1 = $urandom_range(0, cw - 1);
      code[i1] = ~code[i1];
    end
    if (nerr >= 2) begin
      i2 = $urandom_range(0, cw - 1);
      while (i2 == i1) i2 = $urandom_range(0, cw - 1);
      code[i2] = ~code[i2];
    end
    if (nerr == 0) begin
      exp_err  = 2'b00;
      exp_data = data;
    end else if (nerr == 1) begin
      exp_err  = 2'b01;
      exp_data = data;
    end else begin
      exp_err  = 2'b10;
      exp_data = ref_extract(code, ip, par, ext);
    end
  endtask

  // ---------------- B: out_ready source ----------------
  logic b_rand_ready = 1'b0;
  logic b_rand_bit   = 1'b1;
  logic b_fixed_ready;
  assign b_out_ready = b_rand_ready ? b_rand_bit : b_fixed_ready;

  always @(posedge clk) begin
    #1;
    b_rand_bit = ($urandom_range(0, 3) != 0);
  end

  // ---------------- B: scoreboard ----------------
  logic [12:0] exp_q[$];
  logic [12:0] b_exp;
  int b_model_corr   = 0;
  int b_model_uncorr = 0;

  always @(negedge clk) begin : b_scoreboard
    logic [12:0] item;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (b_out_valid && b_out_ready) begin
        if (exp_q.size() == 0) begin
          check("b_unexpected_output", 32'(b_out_valid), 32'(0));
        end else begin
          item = exp_q.pop_front();
          check("b_data", 32'(b_out_data), 32'(item[10:0]));
          check("b_err", 32'(b_out_err), 32'(item[12:11]));
          if (item[12:11] == 2'b01) b_model_corr++;
          if (item[12:11] == 2'b10) b_model_uncorr++;
        end
      end
      if (b_in_valid && b_in_ready) exp_q.push_back(b_exp);
    end
  end

  // Called #1 after a rising edge; returns #1 after the edge that accepted the word.
  task automatic b_send(input logic [15:0] code, input logic [12:0] exp);
    bit done;
    done       = 1'b0;
    b_in_valid = 1'b1;
    b_in_code  = code;
    b_exp      = exp;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      done = b_in_ready;
      @(posedge clk);
      #1;
    end
    if (!done) check("b_send_timeout", 32'(done), 32'(1));
    b_in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    check("watchdog", 32'(0), 32'(1));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] code, d;
    logic [1:0]  e;
    logic [31:0] w_code[4];
    logic [31:0] w_data[4];
    logic [1:0]  w_err[4];

    rst = 1'b1;
    a_in_valid = 0; a_in_code = '0; a_out_ready = 1; a_clr = 0;
    b_in_valid = 0; b_in_code = '0; b_fixed_ready = 1; b_clr = 0; b_exp = '0;
    c_in_valid = 0; c_in_code = '0; c_out_ready = 1; c_clr = 0;
    repeat (2) tick();

    // Reset state
    check("a_rst_out_valid", 32'(a_out_valid), 32'(0));
    check("a_rst_out_data", 32'(a_out_data), 32'(0));
    check("a_rst_out_err", 32'(a_out_err), 32'(0));
    check("b_rst_out_valid", 32'(b_out_valid), 32'(0));
    check("c_rst_corr", 32'(c_corr), 32'(0));
    check("c_rst_uncorr", 32'(c_uncorr), 32'(0));
    rst = 1'b0;
    tick();
    check("a_in_ready_after_rst", 32'(a_in_ready), 32'(1));
    check("b_in_ready_after_rst", 32'(b_in_ready), 32'(1));
    check("c_in_ready_after_rst", 32'(c_in_ready), 32'(1));

    // A: all-zero then all-one code words, back to back, 2-cycle latency
    a_in_valid = 1; a_in_code = 15'h0000;
    tick();                                      // word 0 accepted
    a_in_code = 15'h7FFF;
    check("a_lat_not_early", 32'(a_out_valid), 32'(0));
    tick();                                      // word 1 accepted
    a_in_valid = 0;
    check("a_w0_valid", 32'(a_out_valid), 32'(1));
    check("a_w0_data", 32'(a_out_data), 32'h000);
    check("a_w0_err", 32'(a_out_err), 32'(0));
    tick();
    check("a_w1_valid", 32'(a_out_valid), 32'(1));
    check("a_w1_data", 32'(a_out_data), 32'h7FF);
    check("a_w1_err", 32'(a_out_err), 32'(0));
    tick();
    check("a_drained", 32'(a_out_valid), 32'(0));

    // A: position 5 flipped
    a_in_valid = 1; a_in_code = 15'h0400;
    tick();
    a_in_valid = 0;
    tick();
    check("a_p5_valid", 32'(a_out_valid), 32'(1));
    check("a_p5_data", 32'(a_out_data), 32'h000);
    check("a_p5_err", 32'(a_out_err), 32'(1));
    tick();
    check("a_p5_corr_cnt", 32'(a_corr), 32'(1));
    check("a_p5_uncorr_cnt", 32'(a_uncorr), 32'(0));

    // B: directed SECDED vectors through the scoreboard
    b_send(16'h0001, {2'b01, 11'h000});
    b_send(16'h0003, {2'b10, 11'h001});
    repeat (4) tick();
    check("b_dir_corr_cnt", 32'(b_corr), 32'(1));
    check("b_dir_uncorr_cnt", 32'(b_uncorr), 32'(1));

    // B: backpressure, 4 words with the consumer stalled
    for (int i = 0; i < 4; i++) begin
      make_word(11, 4, 1, int'($urandom_range(0, 2)), w_code[i], w_data[i], w_err[i]);
    end
    b_fixed_ready = 0;
    b_send(w_code[0][15:0], {w_err[0], w_data[0][10:0]});
    b_send(w_code[1][15:0], {w_err[1], w_data[1][10:0]});
    check("bp_in_ready_low", 32'(b_in_ready), 32'(0));
    check("bp_out_valid", 32'(b_out_valid), 32'(1));
    b_in_valid = 1; b_in_code = w_code[2][15:0]; b_exp = {w_err[2], w_data[2][10:0]};
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_stall_in_ready", 32'(b_in_ready), 32'(0));
      check("bp_stall_data", 32'(b_out_data), 32'(w_data[0][10:0]));
      check("bp_stall_err", 32'(b_out_err), 32'(w_err[0]));
    end
    b_fixed_ready = 1;
    b_send(w_code[2][15:0], {w_err[2], w_data[2][10:0]});
    b_send(w_code[3][15:0], {w_err[3], w_data[3][10:0]});
    repeat (6) tick();
    check("bp_all_drained", 32'(exp_q.size()), 32'(0));

    // B: random stream with random backpressure
    b_rand_ready = 1;
    for (int i = 0; i < 200; i++) begin
      make_word(11, 4, 1, int'($urandom_range(0, 2)), code, d, e);
      b_send(code[15:0], {e, d[10:0]});
      repeat ($urandom_range(0, 1)) tick();
    end
    b_rand_ready = 0;
    repeat (6) tick();
    check("b_queue_empty", 32'(exp_q.size()), 32'(0));
    check("b_corr_cnt", 32'(b_corr), 32'(b_model_corr));
    check("b_uncorr_cnt", 32'(b_uncorr), 32'(b_model_uncorr));

    // C: shortened code, syndrome 13 beyond HAM_W=12
    c_in_valid = 1; c_in_code = 12'h801;
    tick();
    c_in_valid = 0;
    tick();
    check("c_short_valid", 32'(c_out_valid), 32'(1));
    check("c_short_err", 32'(c_out_err), 32'(2));
    check("c_short_data", 32'(c_out_data), 32'h01);
    tick();
    check("c_short_uncorr_cnt", 32'(c_uncorr), 32'(1));

    // C: five corrected words saturate a 2-bit counter at 3
    c_in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      make_word(8, 4, 0, 1, code, d, e);
      c_in_code = code[11:0];
      tick();
    end
    c_in_valid = 0;
    repeat (4) tick();
    check("c_corr_saturated", 32'(c_corr), 32'(3));
    check("c_uncorr_kept", 32'(c_uncorr), 32'(1));

    // C: clear on the same cycle as a corrected-word handshake
    make_word(8, 4, 0, 1, code, d, e);
    c_in_valid = 1; c_in_code = code[11:0];
    tick();
    c_in_valid = 0;
    tick();
    check("c_clr_hs_valid", 32'(c_out_valid), 32'(1));
    c_clr = 1;
    tick();
    c_clr = 0;
    check("c_clr_corr", 32'(c_corr), 32'(0));
    check("c_clr_uncorr", 32'(c_uncorr), 32'(0));

    // C: reset in the middle of a stream
    c_in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      make_word(8, 4, 0, 1, code, d, e);
      c_in_code = code[11:0];
      tick();
    end
    check("c_mid_valid", 32'(c_out_valid), 32'(1));
    check("c_mid_corr", 32'(c_corr), 32'(1));
    rst = 1;
    tick();
    check("c_rst_out_valid", 32'(c_out_valid), 32'(0));
    check("c_rst_corr_cnt", 32'(c_corr), 32'(0));
    check("b_rst_corr_cnt", 32'(b_corr), 32'(0));
    rst = 0;
    c_in_valid = 0;
    tick();
    check("c_post_rst_ready", 32'(c_in_ready), 32'(1));
    check("c_post_rst_valid0", 32'(c_out_valid), 32'(0));
    tick();
    check("c_post_rst_valid1", 32'(c_out_valid), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
